// File: rtl/spi_pkt_pkg.sv
// Shared types and defaults for the SPI packet deframer.
package spi_pkt_pkg;

  localparam int unsigned ByteW = 8;
  localparam logic [ByteW-1:0] SofByteDefault = 8'hA5;
  localparam int unsigned MaxLenDefault = 64;

  typedef enum logic [1:0] {
    StIdle,
    StLen,
    StPayload,
    StChk
  } state_e;

endpackage

// File: rtl/spi_pkt_csum.sv
// XOR checksum accumulator: load seeds with LEN, accum folds in payload bytes.
module spi_pkt_csum
  import spi_pkt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             accum,
  input  logic [ByteW-1:0] din,
  output logic             match
);

  logic [ByteW-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (load) begin
      csum_q <= din;
    end else if (accum) begin
      csum_q <= csum_q ^ din;
    end
  end

  assign match = (csum_q == din);

endmodule

// File: rtl/spi_pkt_deframer.sv
// Pops bytes from the SPI receive FIFO, delimits SOF/LEN/payload/CHK frames and
// streams payload bytes out over valid/ready with start/end/abort pulses and counters.
module spi_pkt_deframer
  import spi_pkt_pkg::*;
#(
  parameter logic [ByteW-1:0] SOF_BYTE  = SofByteDefault,
  parameter int unsigned      MAX_LEN   = MaxLenDefault,
  parameter int unsigned      PKT_CNT_W = 16
) (
  input  logic                 axi_aclk,
  input  logic                 axi_areset,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [ByteW-1:0]     fifo_q,
  input  logic                 abort,
  output logic [ByteW-1:0]     m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 package_start_int,
  output logic                 package_end_int,
  output logic                 pkt_err,
  output logic                 pkt_abort,
  output logic [PKT_CNT_W-1:0] pkt_cnt,
  output logic [7:0]           err_cnt
);

  localparam logic [ByteW-1:0] MaxLenB = ByteW'(MAX_LEN);

  state_e               state_q, state_d;
  logic                 rd_pend_q;
  logic [ByteW-1:0]     remaining_q, remaining_d;
  logic [ByteW-1:0]     m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic                 start_q, start_d;
  logic                 end_q, end_d;
  logic                 err_q, err_d;
  logic                 abort_q, abort_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic                 stall, kill, take;
  logic                 csum_load, csum_acc, csum_match;

  spi_pkt_csum u_csum (
    .clk   (axi_aclk),
    .rst   (axi_areset),
    .load  (csum_load),
    .accum (csum_acc),
    .din   (fifo_q),
    .match (csum_match)
  );

  // A read is issued only when its byte can be absorbed on return.
  assign stall      = (state_q == StPayload) && m_valid_q && !m_ready;
  assign fifo_rd_en = !axi_areset && !fifo_empty && !rd_pend_q && !abort && !stall;
  assign kill       = abort && (state_q != StIdle);
  // Abort beats a byte returning in the same cycle.
  assign take       = rd_pend_q && !kill;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q && !m_ready;
    m_last_d    = m_last_q;
    start_d     = 1'b0;
    end_d       = 1'b0;
    err_d       = 1'b0;
    abort_d     = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;
    err_cnt_d   = err_cnt_q;
    csum_load   = 1'b0;
    csum_acc    = 1'b0;

    if (kill) begin
      state_d   = StIdle;
      abort_d   = 1'b1;
      m_valid_d = 1'b0;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end else if (take) begin
      unique case (state_q)
        StIdle: begin
          if (fifo_q == SOF_BYTE) state_d = StLen;
        end
        StLen: begin
          if (fifo_q == '0 || fifo_q > MaxLenB) begin
            state_d = StIdle;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            state_d     = StPayload;
            remaining_d = fifo_q;
            csum_load   = 1'b1;
            start_d     = 1'b1;
          end
        end
        StPayload: begin
          m_data_d    = fifo_q;
          m_valid_d   = 1'b1;
          m_last_d    = (remaining_q == 8'd1);
          remaining_d = remaining_q - 8'd1;
          csum_acc    = 1'b1;
          if (remaining_q == 8'd1) state_d = StChk;
        end
        StChk: begin
          state_d = StIdle;
          end_d   = 1'b1;
          err_d   = !csum_match;
          if (csum_match) begin
            pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
          end else if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q     <= StIdle;
      rd_pend_q   <= 1'b0;
      remaining_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= fifo_rd_en;
      remaining_q <= remaining_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      start_q     <= start_d;
      end_q       <= end_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign m_data            = m_data_q;
  assign m_valid           = m_valid_q;
  assign m_last            = m_last_q && m_valid_q;
  assign package_start_int = start_q;
  assign package_end_int   = end_q;
  assign pkt_err           = err_q;
  assign pkt_abort         = abort_q;
  assign pkt_cnt           = pkt_cnt_q;
  assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_spi_pkt_deframer.sv
// Bench for spi_pkt_deframer: FIFO emulation, output monitor and a frame-parsing
// reference model compared against the observed payload/end/counter results.
module tb_spi_pkt_deframer;

  typedef logic [7:0] byte_t;
  localparam int MemD = 8192;

  logic        axi_aclk = 1'b0;
  logic        axi_areset = 1'b1;
  logic        fifo_empty, fifo_rd_en, abort = 1'b0, m_ready = 1'b0;
  logic [7:0]  fifo_q = 8'h00, m_data, err_cnt;
  logic        m_valid, m_last, package_start_int, package_end_int, pkt_err, pkt_abort;
  logic [15:0] pkt_cnt;

  byte_t mem [MemD];
  int    wr_ptr = 0, rd_ptr = 0;
  logic  starve_en = 1'b0, starve_q = 1'b0;

  logic [8:0] obs_pay[$];
  logic       obs_end[$];
  int         n_start = 0, n_abort = 0, hs_viol = 0, rd_viol = 0;
  logic       prev_stall = 1'b0, prev_rd = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [8:0] mdl_pay[$];
  logic       mdl_end[$];
  int         mdl_start, mdl_bad, mdl_good;
  int         n_cmp = 0, n_fail = 0;

  spi_pkt_deframer dut (
    .axi_aclk          (axi_aclk),
    .axi_areset        (axi_areset),
    .fifo_empty        (fifo_empty),
    .fifo_rd_en        (fifo_rd_en),
    .fifo_q            (fifo_q),
    .abort             (abort),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_last            (m_last),
    .m_ready           (m_ready),
    .package_start_int (package_start_int),
    .package_end_int   (package_end_int),
    .pkt_err           (pkt_err),
    .pkt_abort         (pkt_abort),
    .pkt_cnt           (pkt_cnt),
    .err_cnt           (err_cnt)
  );

  always #5 axi_aclk = ~axi_aclk;

  // FIFO read side: data appears the cycle after the strobe.
  assign fifo_empty = (rd_ptr == wr_ptr) || starve_q;
  always @(posedge axi_aclk) begin
    if (fifo_rd_en) begin
      fifo_q <= mem[rd_ptr % MemD];
      rd_ptr <= rd_ptr + 1;
    end
    starve_q <= starve_en && ($urandom_range(0, 3) == 0);
  end

  always @(negedge axi_aclk) begin
    if (axi_areset) begin
      prev_stall <= 1'b0;
      prev_rd    <= 1'b0;
    end else begin
      if (m_valid && m_ready) obs_pay.push_back({m_last, m_data});
      if (package_start_int) n_start <= n_start + 1;
      if (package_end_int) obs_end.push_back(pkt_err);
      if (pkt_abort) n_abort <= n_abort + 1;
      if (prev_stall && !pkt_abort && !(m_valid && m_data == prev_data)) hs_viol <= hs_viol + 1;
      if (pkt_err && !package_end_int) hs_viol <= hs_viol + 1;
      if (fifo_rd_en && (prev_rd || fifo_empty || abort)) rd_viol <= rd_viol + 1;
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_rd    <= fifo_rd_en;
    end
  end

  // Reference: scan a byte stream by index and derive what the frames should produce.
  task automatic model_stream(input byte_t s[$]);
    int i, len;
    byte_t x;
    mdl_pay.delete();
    mdl_end.delete();
    mdl_start = 0; mdl_bad = 0; mdl_good = 0;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5 || i + 1 >= s.size()) begin i++; continue; end
      len = int'(s[i+1]);
      i += 2;
      if (len == 0 || len > 64) begin mdl_bad++; continue; end
      if (i + len >= s.size()) break;
      mdl_start++;
      x = byte_t'(len);
      for (int k = 0; k < len; k++) begin
        mdl_pay.push_back({(k == len - 1), s[i+k]});
        x = x ^ s[i+k];
      end
      mdl_end.push_back(s[i+len] != x);
      if (s[i+len] != x) mdl_bad++; else mdl_good++;
      i += len + 1;
    end
  endtask

  task automatic push_bytes(input byte_t s[$]);
    foreach (s[k]) begin
      mem[wr_ptr % MemD] = s[k];
      wr_ptr++;
    end
  endtask

  task automatic play(input byte_t s[$], input int ready_pct, output bit timeout);
    int idle, cyc;
    push_bytes(s);
    idle = 0; cyc = 0; timeout = 1'b0;
    while (idle < 4) begin
      @(posedge axi_aclk); #1;
      m_ready = ($urandom_range(1, 100) <= ready_pct);
      if (rd_ptr == wr_ptr && !m_valid) idle++; else idle = 0;
      cyc++;
      if (cyc > 40 * s.size() + 200) begin timeout = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    axi_areset = 1'b1; abort = 1'b0; m_ready = 1'b0;
    wr_ptr = rd_ptr;
    repeat (3) @(posedge axi_aclk);
    #1 axi_areset = 1'b0;
  endtask

  task automatic test_reset();
    logic [38:0] outs;
    repeat (2) @(posedge axi_aclk);
    #1 outs = {fifo_rd_en, m_data, m_valid, m_last, package_start_int, package_end_int,
               pkt_err, pkt_abort, pkt_cnt, err_cnt};
    n_cmp++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", outs); end
    axi_areset = 1'b0;
    repeat (2) @(posedge axi_aclk);
    #1 outs = {fifo_rd_en, m_data, m_valid, m_last, package_start_int, package_end_int,
               pkt_err, pkt_abort, pkt_cnt, err_cnt};
    n_cmp++;
    if (outs !== '0) begin n_fail++; $display("FAIL idle_outs: got %h want 0", outs); end
  endtask

  task automatic test_good_frame();
    byte_t s[$] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    int bp, be, bs; bit to;
    do_reset();
    bp = obs_pay.size(); be = obs_end.size(); bs = n_start;
    model_stream(s);
    play(s, 100, to);
    n_cmp++;
    if (to || n_start - bs != mdl_start) begin
      n_fail++; $display("FAIL good_start: got %0d want %0d (timeout %0d)", n_start - bs, mdl_start, to);
    end
    n_cmp++;
    if (obs_pay.size() - bp != mdl_pay.size()) begin
      n_fail++; $display("FAIL good_pay_cnt: got %0d want %0d", obs_pay.size() - bp, mdl_pay.size());
    end else foreach (mdl_pay[k]) if (obs_pay[bp+k] !== mdl_pay[k]) begin
      n_fail++; $display("FAIL good_pay[%0d]: got %h want %h", k, obs_pay[bp+k], mdl_pay[k]); break;
    end
    n_cmp++;
    if (obs_end.size() - be != 1 || obs_end[be] !== mdl_end[0]) begin
      n_fail++; $display("FAIL good_end: got %0d ends want 1 with err %0d", obs_end.size() - be, mdl_end[0]);
    end
    n_cmp++;
    if (pkt_cnt !== 16'(mdl_good)) begin
      n_fail++; $display("FAIL good_pkt_cnt: got %0d want %0d", pkt_cnt, mdl_good);
    end
  endtask

  task automatic test_bad_chk();
    byte_t s[$] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    int be; bit to;
    do_reset();
    be = obs_end.size();
    model_stream(s);
    play(s, 100, to);
    n_cmp++;
    if (to || obs_end.size() - be != 1 || obs_end[be] !== mdl_end[0]) begin
      n_fail++; $display("FAIL badchk_end: got %0d ends want 1 with err %0d", obs_end.size() - be, mdl_end[0]);
    end
    n_cmp++;
    if (err_cnt !== 8'(mdl_bad) || pkt_cnt !== 16'(mdl_good)) begin
      n_fail++; $display("FAIL badchk_cnts: got err %0d pkt %0d want err %0d pkt %0d",
                         err_cnt, pkt_cnt, mdl_bad, mdl_good);
    end
  endtask

  task automatic test_bad_len();
    byte_t s[$] = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hA5, 8'h41};
    int be, bs; bit to;
    do_reset();
    be = obs_end.size(); bs = n_start;
    model_stream(s);
    play(s, 100, to);
    n_cmp++;
    if (to || n_start - bs != mdl_start || obs_end.size() - be != mdl_end.size()) begin
      n_fail++; $display("FAIL badlen_ints: got start %0d end %0d want %0d %0d",
                         n_start - bs, obs_end.size() - be, mdl_start, mdl_end.size());
    end
    n_cmp++;
    if (err_cnt !== 8'(mdl_bad)) begin
      n_fail++; $display("FAIL badlen_err_cnt: got %0d want %0d", err_cnt, mdl_bad);
    end
  endtask

  task automatic test_stall();
    byte_t s[$] = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h13};
    byte_t none[$];
    int bp, be, w, viol; bit to;
    do_reset();
    bp = obs_pay.size(); be = obs_end.size();
    model_stream(s);
    push_bytes(s);
    w = 0;
    while (!m_valid && w < 50) begin @(posedge axi_aclk); #1; w++; end
    viol = (w >= 50) ? 1 : 0;
    repeat (5) begin
      @(posedge axi_aclk); #1;
      if (!m_valid || m_data !== 8'hAA || fifo_rd_en) viol++;
    end
    n_cmp++;
    if (viol != 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad cycles want 0", viol); end
    play(none, 100, to);
    n_cmp++;
    if (to || obs_pay.size() - bp != mdl_pay.size() || obs_pay[bp] !== mdl_pay[0]
        || obs_pay[bp+1] !== mdl_pay[1]) begin
      n_fail++; $display("FAIL stall_pay: got %0d bytes want %0d", obs_pay.size() - bp, mdl_pay.size());
    end
    n_cmp++;
    if (obs_end.size() - be != 1 || obs_end[be] !== mdl_end[0]) begin
      n_fail++; $display("FAIL stall_end: got %0d ends want 1 with err %0d", obs_end.size() - be, mdl_end[0]);
    end
  endtask

  task automatic test_abort();
    byte_t s[$] = '{8'hA5, 8'h04, 8'h10};
    byte_t s2[$] = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    int be, ba, w; bit to;
    do_reset();
    be = obs_end.size(); ba = n_abort;
    push_bytes(s);
    w = 0;
    while (!m_valid && w < 50) begin @(posedge axi_aclk); #1; w++; end
    abort = 1'b1;
    @(posedge axi_aclk); #1;
    abort = 1'b0;
    n_cmp++;
    if (w >= 50 || pkt_abort !== 1'b1 || m_valid !== 1'b0 || err_cnt !== 8'd1) begin
      n_fail++; $display("FAIL abort_pulse: got abort %0d valid %0d err_cnt %0d want 1 0 1",
                         pkt_abort, m_valid, err_cnt);
    end
    repeat (4) @(posedge axi_aclk);
    #1;
    n_cmp++;
    if (n_abort - ba != 1 || obs_end.size() != be) begin
      n_fail++; $display("FAIL abort_once: got aborts %0d ends %0d want 1 0", n_abort - ba, obs_end.size() - be);
    end
    model_stream(s2);
    play(s2, 100, to);
    n_cmp++;
    if (to || obs_end.size() - be != 1 || obs_end[be] !== mdl_end[0] || pkt_cnt !== 16'(mdl_good)) begin
      n_fail++; $display("FAIL abort_next: got %0d ends pkt_cnt %0d want 1 end err %0d pkt_cnt %0d",
                         obs_end.size() - be, pkt_cnt, mdl_end[0], mdl_good);
    end
  endtask

  task automatic test_reset_mid();
    byte_t s[$] = '{8'hA5, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    byte_t s2[$] = '{8'hA5, 8'h01, 8'h05, 8'h04};
    logic [38:0] outs;
    int bp, be, w; bit to;
    do_reset();
    m_ready = 1'b1;
    bp = obs_pay.size();
    push_bytes(s);
    w = 0;
    while (!(obs_pay.size() - bp >= 2 && fifo_rd_en) && w < 100) begin @(posedge axi_aclk); #1; w++; end
    axi_areset = 1'b1;
    wr_ptr = rd_ptr;
    @(posedge axi_aclk); #1;
    outs = {fifo_rd_en, m_data, m_valid, m_last, package_start_int, package_end_int,
            pkt_err, pkt_abort, pkt_cnt, err_cnt};
    n_cmp++;
    if (w >= 100 || outs !== '0) begin n_fail++; $display("FAIL midreset_outs: got %h want 0", outs); end
    axi_areset = 1'b0;
    be = obs_end.size();
    model_stream(s2);
    play(s2, 100, to);
    n_cmp++;
    if (to || obs_end.size() - be != 1 || obs_end[be] !== mdl_end[0] || pkt_cnt !== 16'(mdl_good)
        || err_cnt !== 8'(mdl_bad)) begin
      n_fail++; $display("FAIL midreset_next: got pkt_cnt %0d err_cnt %0d want %0d %0d",
                         pkt_cnt, err_cnt, mdl_good, mdl_bad);
    end
  endtask

  task automatic test_back_to_back();
    byte_t s[$] = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h01, 8'hA5, 8'h01, 8'hFF, 8'hFE,
                    8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h03};
    byte_t none[$];
    int bp, be, cyc; bit to;
    starve_en = 1'b0;
    do_reset();
    m_ready = 1'b1;
    bp = obs_pay.size(); be = obs_end.size();
    model_stream(s);
    push_bytes(s);
    cyc = 0;
    while (rd_ptr != wr_ptr && cyc < 1000) begin @(posedge axi_aclk); #1; cyc++; end
    n_cmp++;
    if (cyc != 2 * s.size() - 1) begin
      n_fail++; $display("FAIL b2b_rate: got %0d cycles want %0d", cyc, 2 * s.size() - 1);
    end
    play(none, 100, to);
    n_cmp++;
    if (to || obs_end.size() - be != mdl_end.size() || obs_pay.size() - bp != mdl_pay.size()) begin
      n_fail++; $display("FAIL b2b_counts: got %0d ends %0d bytes want %0d %0d",
                         obs_end.size() - be, obs_pay.size() - bp, mdl_end.size(), mdl_pay.size());
    end else begin
      foreach (mdl_end[k]) if (obs_end[be+k] !== mdl_end[k]) begin
        n_fail++; $display("FAIL b2b_end[%0d]: got %0d want %0d", k, obs_end[be+k], mdl_end[k]); break;
      end
    end
    n_cmp++;
    if (pkt_cnt !== 16'(mdl_good)) begin
      n_fail++; $display("FAIL b2b_pkt_cnt: got %0d want %0d", pkt_cnt, mdl_good);
    end
  endtask

  task automatic test_random();
    byte_t s[$];
    byte_t x, p;
    int bp, be, bs, kind, len, hv, rv; bit to;
    do_reset();
    starve_en = 1'b1;
    for (int f = 0; f < 30; f++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        x = 8'($urandom_range(0, 255));
        s.push_back((x == 8'hA5) ? 8'h5A : x);
      end
      kind = $urandom_range(0, 9);
      s.push_back(8'hA5);
      if (kind == 0) begin
        len = $urandom_range(0, 2);
        s.push_back((len == 0) ? 8'h00 : (len == 1) ? 8'h41 : 8'($urandom_range(66, 255)));
        continue;
      end
      len = (kind == 1) ? 64 : (kind == 3) ? 1 : $urandom_range(1, 12);
      s.push_back(8'(len));
      x = 8'(len);
      for (int k = 0; k < len; k++) begin
        p = 8'($urandom_range(0, 255));
        s.push_back(p);
        x = x ^ p;
      end
      if (kind == 2) x = x ^ 8'($urandom_range(1, 255));
      s.push_back(x);
    end
    bp = obs_pay.size(); be = obs_end.size(); bs = n_start; hv = hs_viol; rv = rd_viol;
    model_stream(s);
    play(s, 60, to);
    starve_en = 1'b0;
    n_cmp++;
    if (to || n_start - bs != mdl_start) begin
      n_fail++; $display("FAIL rnd_start: got %0d want %0d (timeout %0d)", n_start - bs, mdl_start, to);
    end
    n_cmp++;
    if (obs_pay.size() - bp != mdl_pay.size()) begin
      n_fail++; $display("FAIL rnd_pay_cnt: got %0d want %0d", obs_pay.size() - bp, mdl_pay.size());
    end else foreach (mdl_pay[k]) if (obs_pay[bp+k] !== mdl_pay[k]) begin
      n_fail++; $display("FAIL rnd_pay[%0d]: got %h want %h", k, obs_pay[bp+k], mdl_pay[k]); break;
    end
    n_cmp++;
    if (obs_end.size() - be != mdl_end.size()) begin
      n_fail++; $display("FAIL rnd_end_cnt: got %0d want %0d", obs_end.size() - be, mdl_end.size());
    end else foreach (mdl_end[k]) if (obs_end[be+k] !== mdl_end[k]) begin
      n_fail++; $display("FAIL rnd_end[%0d]: got %0d want %0d", k, obs_end[be+k], mdl_end[k]); break;
    end
    n_cmp++;
    if (pkt_cnt !== 16'(mdl_good) || err_cnt !== 8'(mdl_bad)) begin
      n_fail++; $display("FAIL rnd_cnts: got pkt %0d err %0d want %0d %0d", pkt_cnt, err_cnt, mdl_good, mdl_bad);
    end
    n_cmp++;
    if (hs_viol != hv || rd_viol != rv) begin
      n_fail++; $display("FAIL rnd_protocol: got %0d handshake %0d read violations want 0 0",
                         hs_viol - hv, rd_viol - rv);
    end
  endtask

  task automatic test_err_sat();
    byte_t s[$];
    int bs, want; bit to;
    do_reset();
    for (int k = 0; k < 260; k++) begin s.push_back(8'hA5); s.push_back(8'h00); end
    bs = n_start;
    model_stream(s);
    want = (mdl_bad > 255) ? 255 : mdl_bad;
    play(s, 100, to);
    n_cmp++;
    if (to || err_cnt !== 8'(want) || n_start != bs || pkt_cnt !== 16'd0) begin
      n_fail++; $display("FAIL err_sat: got err_cnt %0d starts %0d want %0d 0", err_cnt, n_start - bs, want);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_len();
    test_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_err_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
